acc_alu_stage: RTL and testbench

- 4-bit execute stage for the 4-bit CPU.
- Holds the accumulator and the carry/zero flags.
- Consumes one decoded opcode and operand per transaction over a valid/ready handshake.
- Add/subtract paths use a ripple chain of the shared full_adder cells; MUL is a multi-cycle shift-and-add sequence.

---
 rtl/cpu4_pkg.sv | 21 ++
 rtl/adder_ripple.sv | 28 ++
 rtl/full_adder.sv | 13 +
 rtl/acc_alu_stage.sv | 150 +++++++++++++++
 tb/tb_acc_alu_stage.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/cpu4_pkg.sv
// Shared definitions for the 4-bit CPU: default datapath width, opcode
// encodings and the execute-stage state encoding.
package cpu4_pkg;

    localparam int DEF_WIDTH = 4;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_ADC  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/adder_ripple.sv
// WIDTH-bit ripple-carry adder built from a chain of full_adder cells.
module adder_ripple #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] chain;

    assign chain[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (chain[i]),
            .sum (sum[i]),
            .cout(chain[i+1])
        );
    end

    assign cout = chain[WIDTH];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of every carry chain in the CPU.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/acc_alu_stage.sv
// Execute stage of the 4-bit CPU: accumulator, carry/zero flags, single-cycle
// ALU ops and a WIDTH-cycle shift-and-add multiply sharing one ripple adder.
module acc_alu_stage
    import cpu4_pkg::*;
#(
    parameter int WIDTH = cpu4_pkg::DEF_WIDTH
) (
    input  logic             C,
    input  logic             notRST,
    // Handshake: a transaction transfers on a rising C edge where in_valid
    // and in_ready are both high; op/operand are sampled only on that edge.
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero,
    output logic             out_valid,
    output logic             busy,
    output state_t           stateDbg
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state, stateNext;
    logic [WIDTH-1:0]   accNext;
    logic               carryNext, zeroNext, outValidNext;
    logic [WIDTH-1:0]   mcand, mcandNext;
    logic [2*WIDTH-1:0] product, productNext, prodStep;
    logic [CNT_W-1:0]   cnt, cntNext;

    logic [WIDTH-1:0]   addA, addB, addSum;
    logic               addCin, addCout;

    // In MUL the adder works on the upper product half; the multiplier sits
    // in the lower half and is consumed one bit per cycle from bit 0.
    always_comb begin
        addA   = acc;
        addB   = operand;
        addCin = 1'b0;
        if (state == ST_MUL) begin
            addA = product[2*WIDTH-1:WIDTH];
            addB = product[0] ? mcand : '0;
        end else if (op == OP_SUB) begin
            addB   = ~operand;
            addCin = 1'b1;
        end else if (op == OP_ADC) begin
            addCin = carry;
        end
    end

    adder_ripple #(.WIDTH(WIDTH)) u_adder (
        .a   (addA),
        .b   (addB),
        .cin (addCin),
        .sum (addSum),
        .cout(addCout)
    );

    always_comb begin
        stateNext    = state;
        accNext      = acc;
        carryNext    = carry;
        zeroNext     = zero;
        outValidNext = 1'b0;
        mcandNext    = mcand;
        productNext  = product;
        cntNext      = cnt;
        prodStep     = {addCout, addSum, product[WIDTH-1:1]};

        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    outValidNext = 1'b1;
                    case (op)
                        OP_LOAD: begin
                            accNext   = operand;
                            carryNext = 1'b0;
                        end
                        OP_ADD, OP_SUB, OP_ADC: begin
                            accNext   = addSum;
                            carryNext = addCout;
                        end
                        OP_AND: begin
                            accNext   = acc & operand;
                            carryNext = 1'b0;
                        end
                        OP_OR: begin
                            accNext   = acc | operand;
                            carryNext = 1'b0;
                        end
                        OP_XOR: begin
                            accNext   = acc ^ operand;
                            carryNext = 1'b0;
                        end
                        default: begin
                            stateNext    = ST_MUL;
                            outValidNext = 1'b0;
                            mcandNext    = acc;
                            productNext  = {{WIDTH{1'b0}}, operand};
                            cntNext      = '0;
                        end
                    endcase
                    zeroNext = (accNext == '0);
                end
            end
            ST_MUL: begin
                productNext = prodStep;
                cntNext     = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    stateNext    = ST_IDLE;
                    accNext      = prodStep[WIDTH-1:0];
                    carryNext    = |prodStep[2*WIDTH-1:WIDTH];
                    zeroNext     = (prodStep[WIDTH-1:0] == '0);
                    outValidNext = 1'b1;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge C or negedge notRST) begin
        if (!notRST) begin
            state     <= ST_IDLE;
            acc       <= '0;
            carry     <= 1'b0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
            mcand     <= '0;
            product   <= '0;
            cnt       <= '0;
        end else begin
            state     <= stateNext;
            acc       <= accNext;
            carry     <= carryNext;
            zero      <= zeroNext;
            out_valid <= outValidNext;
            mcand     <= mcandNext;
            product   <= productNext;
            cnt       <= cntNext;
        end
    end

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state == ST_MUL);
    assign stateDbg = state;

endmodule

// File: tb/tb_acc_alu_stage.sv
// Directed bench for acc_alu_stage: table of single-cycle ops plus
// hand-written MUL and mid-MUL reset sequences.
module tb_acc_alu_stage;
    import cpu4_pkg::*;

    localparam int W = 4;

    logic         C;
    logic         notRST;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] operand;
    logic [W-1:0] acc;
    logic         carry;
    logic         zero;
    logic         out_valid;
    logic         busy;
    state_t       stateDbg;

    int checks = 0;
    int errors = 0;

    acc_alu_stage #(.WIDTH(W)) dut (
        .C        (C),
        .notRST   (notRST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .operand  (operand),
        .acc      (acc),
        .carry    (carry),
        .zero     (zero),
        .out_valid(out_valid),
        .busy     (busy),
        .stateDbg (stateDbg)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] operand;
        logic [W-1:0] expAcc;
        logic         expCarry;
        logic         expZero;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkResult(input string tag, input logic [W-1:0] eAcc, input logic eCarry,
                               input logic eZero);
        check({tag, " acc"}, 8'(acc), 8'(eAcc));
        check({tag, " carry"}, 8'(carry), 8'(eCarry));
        check({tag, " zero"}, 8'(zero), 8'(eZero));
    endtask

    // One accepted op; returns #1 after the accepting edge.
    task automatic applyOp(input logic [2:0] o, input logic [W-1:0] b);
        in_valid = 1'b1;
        op       = o;
        operand  = b;
        @(posedge C);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic mulSeq(input logic [W-1:0] b, input logic [W-1:0] startAcc,
                          input logic [W-1:0] eAcc, input logic eCarry);
        applyOp(OP_MUL, b);
        for (int i = 0; i < W; i++) begin
            check("mul in_ready", 8'(in_ready), 8'(0));
            check("mul busy", 8'(busy), 8'(1));
            check("mul out_valid", 8'(out_valid), 8'(0));
            check("mul state", 8'(stateDbg), 8'(ST_MUL));
            check("mul acc hold", 8'(acc), 8'(startAcc));
            if (i == 1) begin
                in_valid = 1'b1;
                op       = OP_LOAD;
                operand  = 4'hA;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge C);
            #1;
        end
        checkResult("mul", eAcc, eCarry, (eAcc == '0));
        check("mul done out_valid", 8'(out_valid), 8'(1));
        check("mul done in_ready", 8'(in_ready), 8'(1));
        check("mul done busy", 8'(busy), 8'(0));
        @(posedge C);
        #1;
        check("mul pulse end", 8'(out_valid), 8'(0));
        check("mul acc kept", 8'(acc), 8'(eAcc));
    endtask

    initial begin
        vecs[0]  = '{OP_LOAD, 4'h9, 4'h9, 1'b0, 1'b0};
        vecs[1]  = '{OP_ADD,  4'h8, 4'h1, 1'b1, 1'b0};
        vecs[2]  = '{OP_LOAD, 4'h3, 4'h3, 1'b0, 1'b0};
        vecs[3]  = '{OP_SUB,  4'h3, 4'h0, 1'b1, 1'b1};
        vecs[4]  = '{OP_SUB,  4'h1, 4'hF, 1'b0, 1'b0};
        vecs[5]  = '{OP_LOAD, 4'hF, 4'hF, 1'b0, 1'b0};
        vecs[6]  = '{OP_ADD,  4'h1, 4'h0, 1'b1, 1'b1};
        vecs[7]  = '{OP_ADC,  4'h2, 4'h3, 1'b0, 1'b0};
        vecs[8]  = '{OP_AND,  4'h1, 4'h1, 1'b0, 1'b0};
        vecs[9]  = '{OP_OR,   4'h6, 4'h7, 1'b0, 1'b0};
        vecs[10] = '{OP_XOR,  4'h3, 4'h4, 1'b0, 1'b0};
        vecs[11] = '{OP_ADC,  4'hF, 4'h3, 1'b1, 1'b0};
        vecs[12] = '{OP_ADC,  4'h0, 4'h4, 1'b0, 1'b0};
        vecs[13] = '{OP_LOAD, 4'h1, 4'h1, 1'b0, 1'b0};
        vecs[14] = '{OP_ADD,  4'h1, 4'h2, 1'b0, 1'b0};
        vecs[15] = '{OP_XOR,  4'h3, 4'h1, 1'b0, 1'b0};

        notRST   = 1'b0;
        in_valid = 1'b0;
        op       = OP_LOAD;
        operand  = '0;
        #12;
        checkResult("reset", 4'h0, 1'b0, 1'b1);
        check("reset out_valid", 8'(out_valid), 8'(0));
        check("reset busy", 8'(busy), 8'(0));
        check("reset in_ready", 8'(in_ready), 8'(1));
        check("reset state", 8'(stateDbg), 8'(ST_IDLE));
        notRST = 1'b1;
        @(posedge C);
        #1;
        check("idle out_valid", 8'(out_valid), 8'(0));

        // Back-to-back ops with in_valid held high throughout.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            op       = vecs[i].op;
            operand  = vecs[i].operand;
            @(posedge C);
            #1;
            checkResult($sformatf("vec%0d", i), vecs[i].expAcc, vecs[i].expCarry, vecs[i].expZero);
            check($sformatf("vec%0d out_valid", i), 8'(out_valid), 8'(1));
            check($sformatf("vec%0d in_ready", i), 8'(in_ready), 8'(1));
        end
        in_valid = 1'b0;
        @(posedge C);
        #1;
        check("idle after table out_valid", 8'(out_valid), 8'(0));
        check("idle after table acc", 8'(acc), 8'(1));

        applyOp(OP_LOAD, 4'h3);
        mulSeq(4'h5, 4'h3, 4'hF, 1'b0);
        applyOp(OP_LOAD, 4'h6);
        mulSeq(4'h3, 4'h6, 4'h2, 1'b1);
        applyOp(OP_LOAD, 4'hF);
        mulSeq(4'hF, 4'hF, 4'h1, 1'b1);
        applyOp(OP_LOAD, 4'h5);
        mulSeq(4'h0, 4'h5, 4'h0, 1'b0);

        // Reset two cycles into a MUL aborts it without a result pulse.
        applyOp(OP_LOAD, 4'h7);
        applyOp(OP_MUL, 4'h7);
        @(posedge C);
        #1;
        @(posedge C);
        #1;
        check("pre-abort busy", 8'(busy), 8'(1));
        notRST = 1'b0;
        #1;
        checkResult("abort", 4'h0, 1'b0, 1'b1);
        check("abort out_valid", 8'(out_valid), 8'(0));
        check("abort busy", 8'(busy), 8'(0));
        check("abort in_ready", 8'(in_ready), 8'(1));
        @(posedge C);
        #1;
        notRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge C);
            #1;
            check("post-abort out_valid", 8'(out_valid), 8'(0));
            check("post-abort state", 8'(stateDbg), 8'(ST_IDLE));
        end
        applyOp(OP_LOAD, 4'h4);
        checkResult("post-abort load", 4'h4, 1'b0, 1'b0);
        check("post-abort load out_valid", 8'(out_valid), 8'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
